// File: rtl/sd_rx_fifo_drain_pkg.sv
// Shared types and constants for the SD receive-FIFO drain controller.
package sd_rx_fifo_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/sd_rx_fifo_drain.sv
// Pops words from the SD RX FIFO and writes each one to memory as a single
// Wishbone write, with at most one word in flight at any time.
module sd_rx_fifo_drain
    import sd_rx_fifo_drain_pkg::*;
#(
    parameter int AW    = 32,
    parameter int BLK_W = 10
) (
    input  logic             rclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [AW-1:0]    dma_addr,
    input  logic [BLK_W-1:0] blk_words,
    input  logic [31:0]      fifo_q,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    output logic [AW-1:0]    m_wb_adr_o,
    output logic [31:0]      m_wb_dat_o,
    output logic [3:0]       m_wb_sel_o,
    output logic             m_wb_we_o,
    output logic             m_wb_cyc_o,
    output logic             m_wb_stb_o,
    input  logic             m_wb_ack_i,
    input  logic             m_wb_err_i,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BLK_W-1:0] words_left
);

    state_t           state_reg;
    logic [AW-1:0]    adr_reg;
    logic [31:0]      dat_reg;
    logic [BLK_W-1:0] words_left_reg;
    logic             err_reg;
    logic             done_reg;

    // The pop and the data capture share one edge, so the popped word lands
    // directly in the write-data register and nothing else is buffered.
    assign fifo_rd    = (state_reg == ST_FETCH) && !fifo_empty && !abort;
    assign m_wb_cyc_o = (state_reg == ST_WRITE);
    assign m_wb_stb_o = m_wb_cyc_o;
    assign m_wb_we_o  = m_wb_cyc_o;
    assign m_wb_sel_o = WB_SEL_ALL;
    assign m_wb_adr_o = adr_reg;
    assign m_wb_dat_o = dat_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;
    assign err        = err_reg;
    assign words_left = words_left_reg;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            adr_reg        <= '0;
            dat_reg        <= '0;
            words_left_reg <= '0;
            err_reg        <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // Abort wins over everything; counters and sticky error are kept.
            if (abort) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            if (blk_words != '0) begin
                                adr_reg        <= {dma_addr[AW-1:2], 2'b00};
                                words_left_reg <= blk_words;
                                err_reg        <= 1'b0;
                                state_reg      <= ST_FETCH;
                            end else begin
                                done_reg <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (!fifo_empty) begin
                            dat_reg   <= fifo_q;
                            state_reg <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        if (m_wb_err_i) begin
                            err_reg   <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else if (m_wb_ack_i) begin
                            adr_reg        <= adr_reg + AW'(WORD_BYTES);
                            words_left_reg <= words_left_reg - BLK_W'(1);
                            if (words_left_reg > BLK_W'(1)) begin
                                state_reg <= ST_FETCH;
                            end else begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sd_rx_fifo_drain.md
# sd_rx_fifo_drain

Read-side controller for the SD receive FIFO. It pops 32-bit words from the FIFO and writes them to system memory as single Wishbone master writes, starting at a programmed byte address and stopping after a programmed word count. It sits between the RX FIFO read port and the Wishbone master mux. It runs entirely in the FIFO read-clock domain and reports busy, done and error status to the register block.

## Interface
Parameters:
- AW, 32, Wishbone address width
- BLK_W, 10, width of the word-count input (max 2^BLK_W-1 words per transfer)

Ports:
- rclk, in, 1, controller clock (FIFO read clock)
- rst_n, in, 1, reset. One clock; reset is asynchronous and active-low.
- start, in, 1, one-cycle request; sampled only in IDLE
- abort, in, 1, level; terminates any transfer
- dma_addr, in, AW, start byte address; bits [1:0] ignored (treated as 0)
- blk_words, in, BLK_W, number of 32-bit words to move
- fifo_q, in, 32, FIFO head word (combinational from the FIFO)
- fifo_empty, in, 1, FIFO empty flag
- fifo_rd, out, 1, FIFO pop strobe
- m_wb_adr_o, out, AW, write address
- m_wb_dat_o, out, 32, write data
- m_wb_sel_o, out, 4, byte selects; constant 4'hF
- m_wb_we_o, out, 1, equals m_wb_cyc_o
- m_wb_cyc_o, out, 1, bus cycle
- m_wb_stb_o, out, 1, strobe
- m_wb_ack_i, in, 1, slave acknowledge
- m_wb_err_i, in, 1, slave error
- busy, out, 1, high in any state other than IDLE
- done, out, 1, one-cycle pulse on normal completion
- err, out, 1, sticky bus-error flag; cleared by the next accepted start
- words_left, out, BLK_W, remaining word count

## Operation
States:
- IDLE
  - start=1 and blk_words≠0: latch adr = {dma_addr[AW-1:2],2'b00} and words_left = blk_words; clear err; go to FETCH.
  - start=1 and blk_words=0: pulse done next cycle; stay in IDLE.
- FETCH
  - fifo_rd = (state==FETCH) & !fifo_empty & !abort (combinational).
  - On the same edge fifo_q is latched into m_wb_dat_o and the state goes to WRITE.
  - If fifo_empty, wait in FETCH indefinitely.
- WRITE
  - cyc = stb = 1; address and data held stable.
  - On ack: adr += 4 (wraps modulo 2^AW); words_left -= 1; go to FETCH if words_left was >1, else DONE.
  - On err (err has priority over ack in the same cycle): set err, drop cyc/stb, go to IDLE; no done pulse.
- DONE: done=1 for one cycle, then IDLE.

Abort:
- Checked in every state, with priority over ack, err and start.
- Next edge: cyc/stb drop, state goes to IDLE, words_left holds its value, done is not pulsed, err is unchanged.
- A word already popped but not acked is discarded.

Other rules:
- start while busy is ignored.
- Reset values: state IDLE; all outputs 0 except m_wb_sel_o=4'hF; m_wb_adr_o=0; m_wb_dat_o=0.

## Timing
- start at edge N: busy=1 and state FETCH after N.
- First fifo_rd in cycle N+1 if the FIFO is non-empty.
- stb is asserted in cycle N+2.
- With zero-wait ack, each word takes 2 cycles (FETCH + WRITE). A k-word transfer ends with done high in cycle N+2k+1 and busy low in cycle N+2k+2.
- fifo_rd is never asserted in two consecutive cycles, and never while stb is high.
- At most one word is ever in flight; the controller holds no FIFO occupancy beyond that.
- Reset asserted mid-transfer forces the reset values immediately (asynchronously), including cyc=0.

## Structure
- Shared package sd_rx_fifo_drain_pkg:
  - state enum (IDLE, FETCH, WRITE, DONE)
  - WB_SEL_ALL = 4'hF
  - WORD_BYTES = 4
- Single module; no sub-module. The FSM, address register, data register and word counter all sit in one always_ff block, with the fifo_rd and cyc/stb decode combinational.

## Test plan
- Basic: FIFO preloaded with 4 words 0x11111111..0x44444444, dma_addr=0x1000, blk_words=4, immediate ack -> writes to 0x1000/0x1004/0x1008/0x100C with matching data, 4 fifo_rd pulses, done at cycle N+9, err=0.
- Starvation: FIFO empty at start, one word pushed every 10 cycles, blk_words=3 -> controller waits in FETCH with fifo_rd=0 and cyc=0; exactly 3 writes; done once.
- Wait states: slave acks 3 cycles after stb, blk_words=2 -> adr/dat stable while stb is high; words_left goes 2→1→0 only on ack.
- Bus error: err on the 2nd write of a 5-word transfer -> err=1, cyc=0 next cycle, busy=0, no done, words_left=4; a subsequent start clears err.
- Abort and edge cases:
  - abort asserted during WRITE of word 3 of 8 -> cyc drops next edge, no done, words_left=6, no further fifo_rd.
  - start with blk_words=0 -> done pulse, no bus activity.
  - start while busy -> ignored.
- Wrap and reset: dma_addr=0xFFFFFFFC, blk_words=2 -> second write to 0x00000000. rst_n pulled low mid-WRITE -> all outputs 0 immediately and state IDLE.
